// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register map, control bit positions and FSM states for the RGB PWM generator
package rgb_pwm_pkg;
  localparam logic [2:0] ADDR_DUTY0     = 3'd0;
  localparam logic [2:0] ADDR_DUTY1     = 3'd1;
  localparam logic [2:0] ADDR_DUTY2     = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_RAMP      = 3'd4;
  localparam logic [2:0] ADDR_BLINK_ON  = 3'd5;
  localparam logic [2:0] ADDR_BLINK_OFF = 3'd6;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_BREATHE = 1;
  localparam int CTRL_BLINK   = 2;
  typedef enum logic [1:0] {IDLE, WARM, RUN} state_e;
endpackage

// File: rtl/rgb_pwm_chan.sv
// rgb_pwm_chan: one PWM channel with duty shadow, envelope scaling and registered compare
module rgb_pwm_chan #(
  parameter int PWM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_blink_on,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [PWM_W-1:0] i_scale,
  output logic             o_pwm
);
  localparam int W2 = 2 * PWM_W;
  logic [PWM_W-1:0] r_duty;
  logic [W2-1:0]    w_prod;
  logic [PWM_W-1:0] w_eff;
  assign w_prod = W2'(r_duty) * (W2'(i_scale) + W2'(1));
  assign w_eff  = PWM_W'(w_prod >> PWM_W);
  // duty shadow loads only at period start; output lags the counter compare by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty <= '0;
      o_pwm  <= 1'b0;
    end else begin
      if (i_load) r_duty <= i_duty;
      o_pwm <= i_run & i_blink_on & (i_cnt < w_eff);
    end
  end
endmodule

// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: three-channel PWM front end for the RGB LED current driver
module rgb_pwm_gen
  import rgb_pwm_pkg::*;
#(
  parameter int CLK_DIV  = 12,
  parameter int PWM_W    = 8,
  parameter int WARM_CYC = 1200
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [2:0]       ADDR,
  input  logic [PWM_W-1:0] WDATA,
  output logic             RGBLEDEN,
  output logic             CURREN,
  output logic             RGB0PWM,
  output logic             RGB1PWM,
  output logic             RGB2PWM,
  output logic             BUSY
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int WW = $clog2(WARM_CYC + 1);
  localparam logic [DW-1:0]    DIV_END  = DW'(CLK_DIV - 1);
  localparam logic [WW-1:0]    WARM_END = WW'(WARM_CYC - 1);
  localparam logic [PWM_W-1:0] ONE      = PWM_W'(1);
  logic [PWM_W-1:0] r_duty [3];
  logic [2:0]       r_ctrl;
  logic [PWM_W-1:0] r_ramp, r_bon, r_boff;
  logic             r_brth_s, r_blink_s;
  logic [PWM_W-1:0] r_ramp_s, r_bon_s, r_boff_s;
  state_e           r_state, w_next;
  logic [WW-1:0]    r_warm;
  logic [DW-1:0]    r_div;
  logic [PWM_W-1:0] r_cnt, r_s, r_rcnt, r_bcnt;
  logic             r_up, r_phase;
  logic             w_start, w_run, w_tick, w_pstart, w_load, w_up, w_blink_on;
  logic [PWM_W-1:0] w_ramp_end, w_blen;
  logic [2:0]       w_pwm;
  // register file; address 7 is ignored
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_duty <= '{default: '0};
      r_ctrl <= '0;
      r_ramp <= '0;
      r_bon  <= '0;
      r_boff <= '0;
    end else if (WE) begin
      case (ADDR)
        ADDR_DUTY0:     r_duty[0] <= WDATA;
        ADDR_DUTY1:     r_duty[1] <= WDATA;
        ADDR_DUTY2:     r_duty[2] <= WDATA;
        ADDR_CTRL:      r_ctrl    <= WDATA[2:0];
        ADDR_RAMP:      r_ramp    <= WDATA;
        ADDR_BLINK_ON:  r_bon     <= WDATA;
        ADDR_BLINK_OFF: r_boff    <= WDATA;
        default:        ;
      endcase
    end
  end
  // next state; a low EN returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    if (!r_ctrl[CTRL_EN]) w_next = IDLE;
    else if (r_state == IDLE) w_next = WARM;
    else if (r_state == WARM && r_warm == WARM_END) w_next = RUN;
  end
  // state register
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
  // current-reference settle counter, active only in WARM
  always_ff @(posedge CLK) r_warm <= (RST || r_state != WARM) ? '0 : r_warm + WW'(1);
  assign w_start    = r_state == WARM && w_next == RUN;
  assign w_run      = r_state == RUN && w_next == RUN;
  assign w_tick     = r_div == DIV_END;
  assign w_pstart   = w_run && w_tick && r_cnt == '1;
  assign w_load     = w_start || w_pstart;
  assign w_ramp_end = r_ramp_s == '0 ? '0 : r_ramp_s - ONE;
  assign w_up       = r_up ? r_s != '1 : r_s == '0;
  assign w_blen     = r_phase ? r_bon_s : r_boff_s;
  assign w_blink_on = !r_blink_s || r_boff_s == '0 || (r_bon_s != '0 && r_phase);
  // prescaler and period counter; held at zero outside RUN
  always_ff @(posedge CLK) begin
    if (RST || !w_run) begin
      r_div <= '0;
      r_cnt <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) r_cnt <= r_cnt + ONE;
    end
  end
  // shadow copies of the period-level configuration
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_brth_s  <= 1'b0;
      r_blink_s <= 1'b0;
      r_ramp_s  <= '0;
      r_bon_s   <= '0;
      r_boff_s  <= '0;
    end else if (w_load) begin
      r_brth_s  <= r_ctrl[CTRL_BREATHE];
      r_blink_s <= r_ctrl[CTRL_BLINK];
      r_ramp_s  <= r_ramp;
      r_bon_s   <= r_bon;
      r_boff_s  <= r_boff;
    end
  end
  // breathing envelope and blink phase, both advanced once per period
  always_ff @(posedge CLK) begin
    if (RST || w_next == IDLE) begin
      r_s     <= '0;
      r_up    <= 1'b1;
      r_rcnt  <= '0;
      r_phase <= 1'b1;
      r_bcnt  <= '0;
    end else if (w_start) begin
      r_s     <= r_ctrl[CTRL_BREATHE] ? '0 : '1;
      r_up    <= 1'b1;
      r_rcnt  <= '0;
      r_phase <= 1'b1;
      r_bcnt  <= '0;
    end else if (w_pstart) begin
      if (!r_ctrl[CTRL_BREATHE]) begin
        r_s    <= '1;
        r_up   <= 1'b1;
        r_rcnt <= '0;
      end else if (!r_brth_s) begin
        r_s    <= '0;
        r_up   <= 1'b1;
        r_rcnt <= '0;
      end else if (r_rcnt >= w_ramp_end) begin
        r_s    <= w_up ? r_s + ONE : r_s - ONE;
        r_up   <= w_up;
        r_rcnt <= '0;
      end else begin
        r_rcnt <= r_rcnt + ONE;
      end
      if (r_blink_s && r_bon_s != '0 && r_boff_s != '0) begin
        r_phase <= r_bcnt >= w_blen - ONE ? !r_phase : r_phase;
        r_bcnt  <= r_bcnt >= w_blen - ONE ? '0 : r_bcnt + ONE;
      end else begin
        r_phase <= 1'b1;
        r_bcnt  <= '0;
      end
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_chan
    rgb_pwm_chan #(.PWM_W(PWM_W)) u_chan (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_load     (w_load),
      .i_run      (w_run),
      .i_blink_on (w_blink_on),
      .i_duty     (r_duty[i]),
      .i_cnt      (r_cnt),
      .i_scale    (r_s),
      .o_pwm      (w_pwm[i])
    );
  end
  assign RGBLEDEN = r_state != IDLE;
  assign CURREN   = r_state != IDLE;
  assign BUSY     = r_state != IDLE;
  assign RGB0PWM  = w_pwm[0];
  assign RGB1PWM  = w_pwm[1];
  assign RGB2PWM  = w_pwm[2];
endmodule

// File: tb/tb_rgb_pwm_gen.sv
// tb_rgb_pwm_gen: directed stimulus with a period-level behavioural model checked every cycle
module tb_rgb_pwm_gen;
  localparam int CD = 1;
  localparam int W  = 8;
  localparam int WC = 4;
  localparam int P  = 256 * CD;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic WE = 1'b0;
  logic [2:0] ADDR = '0;
  logic [7:0] WDATA = '0;
  logic RGBLEDEN, CURREN, RGB0PWM, RGB1PWM, RGB2PWM, BUSY;
  int n_chk = 0;
  int n_fail = 0;
  int m_reg [8];
  int m_snap [8];
  int m_age = 0;
  int m_pidx = -1;
  int m_k = 0;
  int m_n = 0;
  logic [2:0] m_pwm = '0;
  bit m_valid = 0;
  int obs [3][300];
  logic [5:0] c_exp, c_act;

  rgb_pwm_gen #(.CLK_DIV(CD), .PWM_W(W), .WARM_CYC(WC)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RGBLEDEN(RGBLEDEN), .CURREN(CURREN),
    .RGB0PWM(RGB0PWM), .RGB1PWM(RGB1PWM), .RGB2PWM(RGB2PWM), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int tri_s(int m);
    int r = m % 510;
    return r <= 255 ? r : 510 - r;
  endfunction

  function automatic bit exp_bit(int ch, int p, int k);
    int ramp = m_snap[4] == 0 ? 1 : m_snap[4];
    int s = (m_snap[3] & 2) != 0 ? tri_s(p / ramp) : 255;
    int d = (m_snap[ch] * (s + 1)) >> 8;
    bit bl = (m_snap[3] & 4) == 0 || m_snap[6] == 0 ||
             (m_snap[5] != 0 && p % (m_snap[5] + m_snap[6]) < m_snap[5]);
    return k < d && bl;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_age = 0;
      m_pidx = -1;
      m_pwm = '0;
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
    end else begin
      m_age = (m_reg[3] & 1) != 0 ? m_age + 1 : 0;
      if (m_age >= WC + 2) begin
        m_n = m_age - WC - 2;
        m_pidx = m_n / P;
        m_k = m_n % P;
        for (int ch = 0; ch < 3; ch++) m_pwm[ch] = exp_bit(ch, m_pidx, m_k / CD);
      end else begin
        m_pidx = -1;
        m_pwm = '0;
      end
      if (m_age >= WC + 1 && (m_age - WC - 1) % P == 0) m_snap = m_reg;
      if (WE && ADDR != 3'd7) m_reg[ADDR] = int'(WDATA);
    end
    m_valid = 1;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      c_exp = {{3{m_age >= 1}}, m_pwm};
      c_act = {RGBLEDEN, CURREN, BUSY, RGB2PWM, RGB1PWM, RGB0PWM};
      n_chk++;
      if (c_act !== c_exp) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t {en,cur,busy,pwm2..0} dut=%b model=%b", $time, c_act, c_exp);
      end
      if (m_pidx >= 0 && m_pidx < 300)
        for (int ch = 0; ch < 3; ch++) begin
          if (m_k == 0) obs[ch][m_pidx] = 0;
          obs[ch][m_pidx] += int'(c_act[ch]);
        end
    end
  end

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(int a, int d);
    ADDR = 3'(a);
    WDATA = 8'(d);
    WE = 1'b1;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic wait_idx(int idx);
    for (int i = 0; i < 80000 && m_age - WC - 1 != idx; i++) @(negedge CLK);
    check("wait_idx", m_age - WC - 1, idx);
  endtask

  task automatic enable_check(string tag, int ctrl);
    int hi;
    wr(3, ctrl);
    check({tag, "_curren_t1"}, int'(CURREN), 0);
    @(negedge CLK);
    check({tag, "_en_cur_busy_t2"}, int'({RGBLEDEN, CURREN, BUSY}), 7);
    hi = int'(RGB0PWM);
    repeat (4) begin
      @(negedge CLK);
      hi += int'(RGB0PWM);
    end
    check({tag, "_warm_pwm_high"}, hi, 0);
    @(negedge CLK);
    check({tag, "_first_pwm"}, int'(RGB0PWM), 1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_outputs", int'({RGBLEDEN, CURREN, BUSY, RGB2PWM, RGB1PWM, RGB0PWM}), 0);
    RST = 1'b0;
    @(negedge CLK);
    wr(0, 64);
    wr(1, 0);
    wr(2, 255);
    enable_check("static", 1);
    wait_idx(2 * P + 2);
    check("static_p0_ch0", obs[0][0], 64);
    check("static_p1_ch0", obs[0][1], 64);
    check("static_p1_ch1", obs[1][1], 0);
    check("static_p1_ch2", obs[2][1], 255);
    wait_idx(2 * P + 77);
    wr(3, 0);
    check("disable_t1_ch2", int'(RGB2PWM), 1);
    @(negedge CLK);
    check("disable_t2_outs", int'({RGBLEDEN, CURREN, BUSY, RGB2PWM, RGB1PWM, RGB0PWM}), 0);
    repeat (5) @(negedge CLK);
    wr(0, 32);
    wr(1, 10);
    wr(3, 1);
    wait_idx(P + 100);
    wr(0, 200);
    wait_idx(2 * P - 1);
    wr(1, 50);
    wait_idx(4 * P + 2);
    check("mid_p0_ch0", obs[0][0], 32);
    check("mid_p1_ch0", obs[0][1], 32);
    check("mid_p2_ch0", obs[0][2], 200);
    check("edge_p2_ch1", obs[1][2], 10);
    check("edge_p3_ch1", obs[1][3], 50);
    wr(3, 0);
    repeat (5) @(negedge CLK);
    wr(0, 128);
    wr(5, 2);
    wr(6, 3);
    wr(3, 5);
    wait_idx(7 * P + 2);
    check("blink_p0", obs[0][0], 128);
    check("blink_p1", obs[0][1], 128);
    check("blink_p2", obs[0][2], 0);
    check("blink_p3", obs[0][3], 0);
    check("blink_p4", obs[0][4], 0);
    check("blink_p5", obs[0][5], 128);
    check("blink_p6", obs[0][6], 128);
    wr(3, 0);
    repeat (5) @(negedge CLK);
    wr(0, 255);
    wr(4, 1);
    wr(3, 3);
    wait_idx(258 * P + 2);
    check("breathe_p0", obs[0][0], 0);
    check("breathe_p1", obs[0][1], 1);
    check("breathe_p2", obs[0][2], 2);
    check("breathe_p128", obs[0][128], 128);
    check("breathe_p255", obs[0][255], 255);
    check("breathe_p256", obs[0][256], 254);
    check("breathe_p257", obs[0][257], 253);
    wait_idx(258 * P + 40);
    check("pre_rst_busy", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_outs", int'({RGBLEDEN, CURREN, BUSY, RGB2PWM, RGB1PWM, RGB0PWM}), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    wr(0, 64);
    enable_check("reen", 1);
    wait_idx(P + 2);
    check("reen_p0_ch0", obs[0][0], 64);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_gen.md
# rgb_pwm_gen

Three-channel PWM generator that produces the RGB0PWM/RGB1PWM/RGB2PWM, RGBLEDEN and CURREN inputs of the on-chip RGB LED current driver. It sits between the SoC register bus and the driver primitive. It provides static duty, a breathing envelope, blink gating, and a current-reference warm-up before PWM starts.

## Interface
- CLK_DIV, 12: system clocks per PWM tick (≥1)
- PWM_W, 8: duty and period resolution; period = 2^PWM_W ticks
- WARM_CYC, 1200: CLK cycles with CURREN high before PWM runs (current-reference settle)

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- WE  in  1  register write strobe, one-cycle
- ADDR  in  3  register address
- WDATA  in  PWM_W  write data
- RGBLEDEN  out  1  driver enable
- CURREN  out  1  current-reference enable
- RGB0PWM, RGB1PWM, RGB2PWM  out  1  per-channel PWM; each is a registered output
- BUSY  out  1  high in WARM or RUN

## Operation
- Registers, all reset to 0:
  - 0–2: DUTY0..2
  - 3: CTRL, with bit0 EN, bit1 BREATHE, bit2 BLINK
  - 4: RAMP, PWM periods per envelope step (0 treated as 1)
  - 5: BLINK_ON, in periods
  - 6: BLINK_OFF, in periods
  - Address 7: writes ignored.
- FSM states: IDLE, WARM, RUN.
  - IDLE: RGBLEDEN=CURREN=0, PWM outputs 0. Moves to WARM when EN=1.
  - WARM: RGBLEDEN=CURREN=1, PWM outputs 0. Counts WARM_CYC cycles, then moves to RUN with tick and period counters at 0.
  - RUN: RGBLEDEN=CURREN=1, PWM active.
  - Any state with EN=0 goes to IDLE on the next cycle.
- Prescaler: a counter from 0 to CLK_DIV-1 produces a one-cycle tick. The PWM_W-bit period counter advances on each tick. Period start is a tick with the counter wrapping to 0.
- Shadowing:
  - DUTYn, RAMP, BLINK_ON/OFF and the BREATHE/BLINK bits are copied to shadow registers at each period start.
  - The copy also happens on the WARM→RUN transition.
  - EN is never shadowed.
- Envelope scale S (PWM_W bits):
  - BREATHE=0: S is held at all-ones.
  - BREATHE=1: S starts at 0 and moves one step every RAMP periods in a triangle wave 0→max→0. At each end it reverses direction without repeating the end value.
  - Clearing BREATHE forces S to max at the next period start.
- Effective duty: Dn = (DUTYn × (S+1)) >> PWM_W, computed at full 2·PWM_W width and then truncated.
- Channel output: RGBnPWM = (cnt < Dn) & blink_on. Dn=0 gives a constant 0. Maximum duty gives high for (2^PWM_W − 1) of 2^PWM_W ticks.
- Blink:
  - BLINK=1 alternates an ON phase of BLINK_ON periods and an OFF phase of BLINK_OFF periods, starting in ON.
  - A length of 0 means the phase is skipped; if both lengths are 0, output stays ON.
  - BLINK=0 forces ON.

## Timing
- Reset and IDLE values: all outputs 0, all counters 0, S=0, blink phase ON, blink counter 0.
- EN write at cycle t: RGBLEDEN/CURREN go high at t+2 (register write, then FSM). The first PWM high appears WARM_CYC+1 cycles later.
- EN cleared: all outputs are 0 one cycle after the FSM leaves RUN/WARM, i.e. t+2. This applies mid-period and mid-warm-up; no partial period is completed.
- Output latency: RGBnPWM is registered, one CLK after the counter compare.
- DUTY write mid-period: no effect until the next period start, so no runt pulses.
- Simultaneous WE and period start: the new value is shadowed in the following period, not this one.
- RST mid-RUN: all outputs go to 0 on the next edge and the FSM returns to IDLE.

## Structure
- Package rgb_pwm_pkg:
  - register address constants: ADDR_DUTY0..2, ADDR_CTRL, ADDR_RAMP, ADDR_BLINK_ON, ADDR_BLINK_OFF
  - CTRL bit indices
  - FSM state enum (IDLE, WARM, RUN)
- Sub-module rgb_pwm_chan, instantiated three times. It holds the duty shadow register, the scale multiply and the compare/output register. Inputs are period counter, S, period-start and blink_on.
- The top holds the register file, FSM, prescaler, period counter, envelope and blink counters.

## Test plan
All tests use CLK_DIV=1, PWM_W=8, WARM_CYC=4.
- Static duty: DUTY0=64, DUTY1=0, DUTY2=255, EN=1 → after 6 cycles, per 256-cycle period RGB0 high 64 cycles, RGB1 never high, RGB2 high 255 cycles. RGBLEDEN=CURREN=1 from t+2.
- Warm-up gating: EN=1 with DUTY0=255 → CURREN high at t+2, and RGB0PWM stays 0 for the next 4 cycles.
- Mid-period write: DUTY0 changes 32→200 at cycle 100 of a period → the current period shows 32 high cycles, the next shows 200.
- Breathe: DUTY0=255, RAMP=1, BREATHE=1 → per-period high counts 0, 1, 2, … up to 255, then 254 back down to 0. The sequence is symmetric with no repeated endpoints.
- Blink: DUTY0=128, BLINK_ON=2, BLINK_OFF=3 → period pattern is 2 periods with 128 high cycles, then 3 periods at 0, repeating.
- Disable/reset: clear EN, or assert RST, at an arbitrary RUN cycle → all outputs 0 within 2 cycles (1 cycle for RST), BUSY=0, and re-enabling repeats the full warm-up.
